// File: rtl/mem_rd_arbiter_pkg.sv
// Shared types and constants for the two-master memory read arbiter.
package mem_rd_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_ADDR = 2'b01,
    ARB_DATA = 2'b11
  } arb_state_e;

  localparam logic [2:0] RESP_OKAY   = 3'h0;
  localparam logic [2:0] RESP_SLVERR = 3'h2;

endpackage

// File: rtl/mem_rd_arbiter_rr_arb2.sv
// Two-input round-robin pick: purely combinational.
// A lone requester always wins; on a tie the one not granted last time wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant,
  output logic       grant_idx
);

  always_comb begin
    grant     = 2'b00;
    grant_idx = 1'b0;
    case (req)
      2'b01: begin
        grant     = 2'b01;
        grant_idx = 1'b0;
      end
      2'b10: begin
        grant     = 2'b10;
        grant_idx = 1'b1;
      end
      2'b11: begin
        grant_idx = ~last_grant;
        grant     = last_grant ? 2'b01 : 2'b10;
      end
      default: begin
        grant     = 2'b00;
        grant_idx = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Shares one AR/R read port between icache (0) and dcache (1), one transaction in flight.
// Grant to mem_arvalid 1 cycle, response pass-through 0 cycles; requester rready stalls memory.
module mem_rd_arbiter
  import mem_rd_arbiter_pkg::*;
#(
  parameter int DATA_LEN = 32,
  parameter int REQ_NUM  = 2
) (
  input  logic                clk,
  input  logic                rst_n,

  input  logic                s0_arvalid,
  output logic                s0_arready,
  input  logic [DATA_LEN-1:0] s0_araddr,
  output logic                s0_rvalid,
  input  logic                s0_rready,
  output logic [2:0]          s0_rresp,
  output logic [DATA_LEN-1:0] s0_rdata,

  input  logic                s1_arvalid,
  output logic                s1_arready,
  input  logic [DATA_LEN-1:0] s1_araddr,
  output logic                s1_rvalid,
  input  logic                s1_rready,
  output logic [2:0]          s1_rresp,
  output logic [DATA_LEN-1:0] s1_rdata,

  output logic                mem_arvalid,
  input  logic                mem_arready,
  output logic [DATA_LEN-1:0] mem_araddr,
  input  logic                mem_rvalid,
  output logic                mem_rready,
  input  logic [2:0]          mem_rresp,
  input  logic [DATA_LEN-1:0] mem_rdata
);

  generate
    if (REQ_NUM != 2) begin : g_bad_req_num
      $error("mem_rd_arbiter supports exactly two requesters");
    end
  endgenerate

  arb_state_e state, next_state;
  logic       owner;
  logic       last_grant;
  logic [1:0] grant;
  logic       grant_idx;
  logic       addr_load;
  logic       data_done;

  rr_arb2 u_rr_arb2 (
    .req        ({s1_arvalid, s0_arvalid}),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    addr_load  = 1'b0;
    data_done  = 1'b0;
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    s0_rvalid  = 1'b0;
    s1_rvalid  = 1'b0;
    s0_rresp   = RESP_OKAY;
    s1_rresp   = RESP_OKAY;
    s0_rdata   = '0;
    s1_rdata   = '0;
    mem_rready = 1'b0;

    case (state)
      ARB_IDLE: begin
        // Reset gating keeps arready low while rst_n is held, even with arvalid up.
        s0_arready = rst_n & grant[0];
        s1_arready = rst_n & grant[1];
        if (rst_n && (grant != 2'b00)) begin
          addr_load  = 1'b1;
          next_state = ARB_ADDR;
        end
      end
      ARB_ADDR: begin
        if (mem_arready) begin
          next_state = ARB_DATA;
        end
      end
      ARB_DATA: begin
        if (owner == 1'b0) begin
          s0_rvalid  = mem_rvalid;
          s0_rresp   = mem_rresp;
          s0_rdata   = mem_rdata;
          mem_rready = s0_rready;
        end else begin
          s1_rvalid  = mem_rvalid;
          s1_rresp   = mem_rresp;
          s1_rdata   = mem_rdata;
          mem_rready = s1_rready;
        end
        if (mem_rvalid && mem_rready) begin
          data_done  = 1'b1;
          next_state = ARB_IDLE;
        end
      end
      default: begin
        next_state = ARB_IDLE;
      end
    endcase
  end

  // mem_arvalid is a pure state decode so it drops the moment reset asserts.
  assign mem_arvalid = (state == ARB_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_araddr <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      if (addr_load) begin
        mem_araddr <= grant_idx ? s1_araddr : s0_araddr;
        owner      <= grant_idx;
      end
      if (data_done) begin
        last_grant <= owner;
      end
    end
  end

endmodule

// File: doc/mem_rd_arbiter.md
Name: mem_rd_arbiter

Overview:
- Shares the single memory-side read port (AR/R channel pair) between two cache refill masters: requester 0 (icache) and requester 1 (dcache).
- The icache refill engine issues one beat per request, so this block supports one outstanding transaction at a time.
- It arbitrates round-robin, latches the winning address, drives the downstream read, and routes the response back to the owner.
- It sits between the cache refill engines and the SRAM/bus read interface.

Parameters:
- DATA_LEN, 32, width of address and read data for requesters and memory.
- REQ_NUM, 2, number of requesters. Fixed at 2; any other value is a build-time error.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s0_arvalid  in  1  icache read-address valid.
- s0_arready  out  1  icache read-address ready.
- s0_araddr  in  DATA_LEN  icache read address.
- s0_rvalid  out  1  icache read-data valid.
- s0_rready  in  1  icache read-data ready.
- s0_rresp  out  3  icache read response.
- s0_rdata  out  DATA_LEN  icache read data.
- s1_arvalid, s1_arready, s1_araddr, s1_rvalid, s1_rready, s1_rresp, s1_rdata: dcache channel, same widths and meaning as s0.
- mem_arvalid  out  1  downstream address valid.
- mem_arready  in  1  downstream address ready.
- mem_araddr  out  DATA_LEN  downstream address.
- mem_rvalid  in  1  downstream data valid.
- mem_rready  out  1  downstream data ready.
- mem_rresp  in  3  downstream response; 3'h0 is OK, anything else is an error and is forwarded unchanged.
- mem_rdata  in  DATA_LEN  downstream data.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state=ARB_IDLE, mem_arvalid=0, mem_araddr=0, owner=0.
  - last_grant=1, so requester 0 wins first.
  - All s*_arready and s*_rvalid are 0 while rst_n is low.
- State ARB_IDLE:
  - Grant is combinational. If exactly one requester has arvalid high, it wins. If both do, the winner is the one not equal to last_grant.
  - s<g>_arready = 1 for the winner only. The loser's arready = 0.
  - On the winner's handshake, register araddr into mem_araddr, set owner=g, set mem_arvalid=1, and go to ARB_ADDR.
  - With no arvalid, stay in ARB_IDLE.
- State ARB_ADDR:
  - mem_arvalid is held at 1 and mem_araddr is stable until mem_arvalid & mem_arready.
  - On that handshake, mem_arvalid is cleared to 0 in the same edge and the state goes to ARB_DATA.
  - Both s*_arready = 0.
- State ARB_DATA:
  - Response path is a zero-latency pass-through to the owner:
    - s<owner>_rvalid = mem_rvalid
    - s<owner>_rdata = mem_rdata
    - s<owner>_rresp = mem_rresp
    - mem_rready = s<owner>_rready
  - The non-owner sees rvalid=0; its rdata and rresp are don't-care but driven to 0.
  - On mem_rvalid & mem_rready, set last_grant=owner and go to ARB_IDLE.
  - Both s*_arready = 0.
- Timing: earliest turnaround is 3 cycles per transaction:
  - request accepted at T;
  - mem_arvalid high at T+1;
  - data earliest at T+2, if the memory accepts at T+1 and responds the next cycle.
  - The next grant is at T+3, because ARB_IDLE is re-entered after the data edge.
- Error responses: mem_rresp != 0 does not alter sequencing. It is forwarded and ends the transaction.
- Simultaneous events:
  - A request from the non-owner during ARB_ADDR/ARB_DATA waits. Its arvalid must be held, per the handshake rule: once valid is high it stays high until ready.
  - mem_rvalid is ignored outside ARB_DATA: mem_rready=0 in ARB_IDLE and ARB_ADDR.
- Reset mid-operation: state returns to ARB_IDLE and mem_arvalid drops immediately. Any in-flight downstream response is dropped; the system resets all masters together.
- Fairness: under continuous requests from both masters, grants strictly alternate 0,1,0,1.

Decomposition:
- Shared package holds:
  - state encoding ARB_IDLE=2'b00, ARB_ADDR=2'b01, ARB_DATA=2'b11;
  - response constants RESP_OKAY=3'h0, RESP_SLVERR=3'h2.
- One sub-module, rr_arb2: combinational two-input round-robin pick. Inputs are the req vector and last_grant; outputs are a one-hot grant and the grant index.
- The FSM, address register and response mux stay in mem_rd_arbiter.

Test Plan:
- Single icache read: s0_araddr=0x8000_0010, mem_arready=1 at the next cycle, mem_rdata=0xDEAD_BEEF with rresp=0 one cycle later → mem_araddr=0x8000_0010 at T+1; s0_rvalid=1 and s0_rdata=0xDEAD_BEEF at T+2; s1_rvalid stays 0.
- Simultaneous requests right after reset: s0=0x100, s1=0x200 held high → grant order 0x100, 0x200, 0x100 on mem_araddr; s1_arready only ever rises in ARB_IDLE after the s0 data handshake.
- Downstream backpressure: mem_arready=0 for 5 cycles → mem_arvalid and mem_araddr stable all 5 cycles, no state change; then proceed normally.
- Requester backpressure: mem_rvalid=1 while s1_rready=0 for 3 cycles (owner=1) → mem_rready=0 for those cycles, state stays ARB_DATA, s1_rdata tracks mem_rdata.
- Error response: mem_rresp=3'h2 for the owner s0 → s0_rresp=3'h2, the transaction completes, and the next pending s1 request is granted.
- Reset asserted in ARB_ADDR with mem_arvalid=1 → mem_arvalid=0 asynchronously; after release, a new s1-only request is granted (last_grant reset to 1 does not block a lone requester).
